hc4e_nibble_port: RTL and testbench

Memory-mapped I/O responder on the HC4e nibble RAM bus (address_bus/data_bus/nRAM_RD/nRAM_WR). It sits on the bus alongside the 16-nibble RAM and answers the CPU's accesses to two reserved addresses.

- **Transmit path:** a CPU write to the data address pushes a nibble into a TX FIFO. The FIFO drains through a valid/ready stream.
- **Receive path:** a valid/ready stream fills an RX FIFO. A CPU read of the data address pops it.
- **Status:** a status address reports FIFO state and sticky error flags.
- **Address ownership:** system decode keeps the RAM off the bus at DATA_ADDR and STAT_ADDR.

---
 rtl/hc4e_nibble_port.sv | 152 +++++++++++++++
 tb/tb_hc4e_nibble_port.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc4e_nibble_port.sv
// HC4e nibble-bus I/O responder: CPU-mapped data/status registers
// bridging a TX FIFO and an RX FIFO onto valid/ready streams.
module hc4e_nibble_port #(
  parameter logic [3:0] DATA_ADDR = 4'hF,
  parameter logic [3:0] STAT_ADDR = 4'hE,
  parameter int         DEPTH     = 8
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic [3:0] address_bus,
  inout  wire  [3:0] data_bus,
  input  logic       nRAM_RD,
  input  logic       nRAM_WR,
  output logic [3:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [3:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam cnt_t FULL = cnt_t'(DEPTH);

  logic       rd_q;
  logic       wr_q;
  logic       rd_act;
  logic [3:0] rd_addr;

  logic [3:0] tx_mem [DEPTH];
  ptr_t       tx_wp;
  ptr_t       tx_rp;
  cnt_t       tx_cnt;

  logic [3:0] rx_mem [DEPTH];
  ptr_t       rx_wp;
  ptr_t       rx_rp;
  cnt_t       rx_cnt;

  logic       tx_ovf;
  logic       rx_err;

  logic       wr_edge;
  logic       rd_start;
  logic       rd_end;
  logic       wr_data;
  logic       wr_stat;
  logic       tx_push;
  logic       tx_pop;
  logic       tx_ovf_set;
  logic       tx_ovf_clr;
  logic       rx_push;
  logic       rx_req;
  logic       rx_pop;
  logic       rx_err_set;
  logic       rx_err_clr;
  logic       rd_drive;
  logic [3:0] rd_val;

  // A write owns the bus when both strobes are low, so reads start only with nRAM_WR high.
  assign wr_edge  = !nRAM_WR && wr_q;
  assign rd_start = !nRAM_RD && rd_q && nRAM_WR;
  assign rd_end   = nRAM_RD && !rd_q && rd_act;
  assign wr_data  = wr_edge && (address_bus == DATA_ADDR);
  assign wr_stat  = wr_edge && (address_bus == STAT_ADDR);

  assign tx_valid   = (tx_cnt != '0);
  assign tx_data    = tx_mem[tx_rp];
  assign tx_push    = wr_data && (tx_cnt != FULL);
  assign tx_pop     = tx_valid && tx_ready;
  assign tx_ovf_set = wr_data && (tx_cnt == FULL);
  assign tx_ovf_clr = wr_stat && data_bus[0];

  assign rx_ready   = nReset && (rx_cnt != FULL);
  assign rx_push    = rx_valid && rx_ready;
  assign rx_req     = rd_end && (rd_addr == DATA_ADDR);
  assign rx_pop     = rx_req && (rx_cnt != '0);
  assign rx_err_set = rx_req && (rx_cnt == '0);
  assign rx_err_clr = wr_stat && data_bus[1];

  assign rd_drive = nReset && !nRAM_RD && nRAM_WR &&
                    ((address_bus == DATA_ADDR) ||
                     (address_bus == STAT_ADDR));

  always_comb begin
    rd_val = {rx_cnt != '0, tx_cnt == FULL, rx_err, tx_ovf};
    if (address_bus == DATA_ADDR) begin
      rd_val = (rx_cnt != '0) ? rx_mem[rx_rp] : 4'h0;
    end
  end

  assign data_bus = rd_drive ? rd_val : 4'bz;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      rd_act  <= 1'b0;
      rd_addr <= 4'h0;
      tx_ovf  <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      rd_q   <= nRAM_RD;
      wr_q   <= nRAM_WR;
      tx_ovf <= tx_ovf_set || (tx_ovf && !tx_ovf_clr);
      rx_err <= rx_err_set || (rx_err && !rx_err_clr);
      if (rd_start) begin
        rd_act  <= 1'b1;
        rd_addr <= address_bus;
      end else if (rd_end) begin
        rd_act <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) tx_mem[i] <= 4'h0;
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp] <= data_bus;
        tx_wp         <= tx_wp + ptr_t'(1);
      end
      if (tx_pop) tx_rp <= tx_rp + ptr_t'(1);
      tx_cnt <= tx_cnt + cnt_t'(tx_push) - cnt_t'(tx_pop);
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) rx_mem[i] <= 4'h0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wp] <= rx_data;
        rx_wp         <= rx_wp + ptr_t'(1);
      end
      if (rx_pop) rx_rp <= rx_rp + ptr_t'(1);
      rx_cnt <= rx_cnt + cnt_t'(rx_push) - cnt_t'(rx_pop);
    end
  end

endmodule

// File: tb/tb_hc4e_nibble_port.sv
// Bench for hc4e_nibble_port: directed vectors, corner sequences and
// randomized traffic against a queue-based model of the port.
module tb_hc4e_nibble_port;

  localparam int DEPTH = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] addr;
  wire  [3:0] data_bus;
  logic [3:0] cpu_d;
  logic       oe;
  logic       nrd;
  logic       nwr;
  logic [3:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rnd;

  int checks;
  int failures;

  assign data_bus = oe ? cpu_d : 4'bz;

  hc4e_nibble_port #(
    .DATA_ADDR(4'hF),
    .STAT_ADDR(4'hE),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .nReset(rst_n),
    .address_bus(addr),
    .data_bus(data_bus),
    .nRAM_RD(nrd),
    .nRAM_WR(nwr),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] txq[$];
  logic [3:0] rxq[$];
  logic       m_ovf;
  logic       m_err;
  logic       m_prd;
  logic       m_pwr;
  logic       m_ract;
  logic [3:0] m_raddr;

  task automatic chk(input string n, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_ovf   = 1'b0;
    m_err   = 1'b0;
    m_prd   = 1'b1;
    m_pwr   = 1'b1;
    m_ract  = 1'b0;
    m_raddr = 4'h0;
  endtask

  // Bus rules applied to the inputs present at a rising edge.
  task automatic model_step();
    bit wr_e, rd_s, rd_e, full, req;
    if (!rst_n) begin
      model_reset();
      return;
    end
    wr_e = !nwr && m_pwr;
    rd_s = !nrd && m_prd && nwr;
    rd_e = nrd && !m_prd && m_ract;
    full = (txq.size() == DEPTH);
    if (txq.size() != 0 && tx_ready) void'(txq.pop_front());
    if (wr_e && addr == 4'hF && !full) txq.push_back(cpu_d);
    m_ovf = (wr_e && addr == 4'hF && full) ||
            (m_ovf && !(wr_e && addr == 4'hE && cpu_d[0]));
    req = rd_e && m_raddr == 4'hF;
    m_err = (req && rxq.size() == 0) ||
            (m_err && !(wr_e && addr == 4'hE && cpu_d[1]));
    if (rx_valid && rxq.size() < DEPTH) begin
      if (req && rxq.size() != 0) void'(rxq.pop_front());
      rxq.push_back(rx_data);
    end else if (req && rxq.size() != 0) begin
      void'(rxq.pop_front());
    end
    if (rd_e) m_ract = 1'b0;
    if (rd_s) begin
      m_ract  = 1'b1;
      m_raddr = addr;
    end
    m_prd = nrd;
    m_pwr = nwr;
  endtask

  function automatic logic [3:0] exp_rd(input logic [3:0] a);
    if (a == 4'hF) return (rxq.size() != 0) ? rxq[0] : 4'h0;
    return {rxq.size() != 0, txq.size() == DEPTH, m_err, m_ovf};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("tx_valid", 4'(tx_valid), 4'(txq.size() != 0));
    if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
    chk("rx_ready", 4'(rx_ready), 4'(rst_n && rxq.size() < DEPTH));
    if (rnd) begin
      tx_ready = 1'($urandom);
      rx_valid = 1'($urandom);
      rx_data  = 4'($urandom);
    end
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [3:0] d);
    addr  = a;
    cpu_d = d;
    oe    = 1'b1;
    nwr   = 1'b0;
    cyc();
    nwr = 1'b1;
    oe  = 1'b0;
    cyc();
  endtask

  task automatic cpu_read(input logic [3:0] a, input int n,
                          output logic [3:0] got);
    addr = a;
    nrd  = 1'b0;
    got  = 4'h0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rd_bus", data_bus, exp_rd(a));
      if (i == 0) got = data_bus;
      cyc();
    end
    nrd = 1'b1;
    cyc();
  endtask

  typedef struct {
    bit         is_rd;
    logic [3:0] a;
    logic [3:0] d;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [3:0] got;
    logic [3:0] seq[8];
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    addr     = 4'h0;
    cpu_d    = 4'h0;
    oe       = 1'b0;
    nrd      = 1'b1;
    nwr      = 1'b1;
    tx_ready = 1'b0;
    rx_data  = 4'h0;
    rx_valid = 1'b0;
    rnd      = 1'b0;
    model_reset();

    for (int k = 0; k < 9; k++) tbl[k] = '{1'b0, 4'hF, 4'(k + 1), 4'h0};
    tbl[9]  = '{1'b1, 4'hE, 4'h0, 4'b0101};
    tbl[10] = '{1'b0, 4'hE, 4'b0001, 4'h0};
    tbl[11] = '{1'b1, 4'hE, 4'h0, 4'b0100};

    // reset state
    repeat (2) cyc();
    chk("rst_tx_data", tx_data, 4'h0);
    rst_n = 1'b1;
    cyc();
    chk("rst_rx_ready", 4'(rx_ready), 4'h1);
    cpu_read(4'hE, 1, got);
    chk("rst_status", got, 4'h0);

    // TX path
    cpu_write(4'hF, 4'hA);
    cpu_write(4'hF, 4'h5);
    chk("tx_head_a", tx_data, 4'hA);
    tx_ready = 1'b1;
    cyc();
    chk("tx_head_5", tx_data, 4'h5);
    cyc();
    chk("tx_empty", 4'(tx_valid), 4'h0);
    tx_ready = 1'b0;

    // RX fill, drain and underflow
    for (int i = 0; i < 8; i++) begin
      seq[i]   = 4'((i * 7) % 16);
      rx_valid = 1'b1;
      rx_data  = seq[i];
      cyc();
    end
    rx_valid = 1'b0;
    chk("rx_full_ready", 4'(rx_ready), 4'h0);
    cpu_read(4'hE, 1, got);
    chk("rx_full_stat", got, 4'b1000);
    cpu_read(4'hF, 2, got);
    chk("rx_rd0", got, 4'h0);
    for (int i = 1; i < 8; i++) begin
      cpu_read(4'hF, 1, got);
      chk("rx_rd_seq", got, seq[i]);
    end
    cpu_read(4'hF, 1, got);
    chk("rx_underflow_val", got, 4'h0);
    cpu_read(4'hE, 1, got);
    chk("rx_underflow_stat", got, 4'b0010);
    cpu_write(4'hE, 4'b0010);
    cpu_read(4'hE, 1, got);
    chk("rx_err_clear", got, 4'h0);

    // TX overflow vectors
    foreach (tbl[k]) begin
      if (tbl[k].is_rd) begin
        cpu_read(tbl[k].a, 1, got);
        chk("tbl_rd", got, tbl[k].exp);
      end else begin
        cpu_write(tbl[k].a, tbl[k].d);
      end
    end

    // full TX: push rejected even though the stream pops on that edge
    addr     = 4'hF;
    cpu_d    = 4'h7;
    oe       = 1'b1;
    nwr      = 1'b0;
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    nwr      = 1'b1;
    oe       = 1'b0;
    cyc();
    chk("full_pop_head", tx_data, 4'h2);
    cpu_read(4'hE, 1, got);
    chk("full_pop_stat", got, 4'b0001);
    cpu_write(4'hE, 4'b1101);
    tx_ready = 1'b1;
    repeat (7) cyc();
    tx_ready = 1'b0;
    chk("tx_drained", 4'(tx_valid), 4'h0);

    // RX read-end pop with simultaneous push across pointer wrap
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1;
      rx_data  = 4'(i + 1);
      cyc();
    end
    rx_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      addr = 4'hF;
      nrd  = 1'b0;
      #1;
      chk("wrap_rd", data_bus, 4'(i + 1));
      cyc();
      nrd      = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 4'(i + 4);
      cyc();
      rx_valid = 1'b0;
      chk("wrap_cnt", 4'(rxq.size()), 4'd3);
    end
    for (int i = 0; i < 3; i++) begin
      cpu_read(4'hF, 1, got);
      chk("wrap_tail", got, 4'(i + 7));
    end

    // empty pop together with a push: error flagged, nibble kept
    addr = 4'hF;
    nrd  = 1'b0;
    cyc();
    nrd      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 4'hC;
    cyc();
    rx_valid = 1'b0;
    cpu_read(4'hE, 1, got);
    chk("empty_pop_push_stat", got, 4'b1010);
    cpu_read(4'hF, 1, got);
    chk("empty_pop_push_val", got, 4'hC);
    cpu_write(4'hE, 4'b0011);

    // both strobes low: write acts
    addr  = 4'hF;
    cpu_d = 4'h3;
    oe    = 1'b1;
    nwr   = 1'b0;
    nrd   = 1'b0;
    cyc();
    nwr = 1'b1;
    nrd = 1'b1;
    oe  = 1'b0;
    cyc();
    chk("both_low_push", tx_data, 4'h3);
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;

    // reset during a read strobe with two RX entries
    for (int i = 0; i < 2; i++) begin
      rx_valid = 1'b1;
      rx_data  = 4'(9 + i);
      cyc();
    end
    rx_valid = 1'b0;
    addr = 4'hF;
    nrd  = 1'b0;
    cyc();
    rst_n = 1'b0;
    model_reset();
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_rd_bus0", data_bus, 4'h0);
    cyc();
    #1;
    chk("rst_rd_bus1", data_bus, 4'h0);
    chk("rst_rx_empty", 4'(rxq.size()), 4'h0);
    nrd = 1'b1;
    cyc();
    // the strobe still low at release counts as a fresh read of an empty FIFO
    cpu_read(4'hE, 1, got);
    chk("rst_rd_stat", got, 4'b0010);
    cpu_write(4'hE, 4'b0011);

    // randomized traffic
    rnd = 1'b1;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 5))
        0: cyc();
        1: cpu_write(4'hF, 4'($urandom));
        2: cpu_write(4'hE, 4'($urandom));
        3: cpu_read(4'hF, int'($urandom_range(1, 3)), got);
        4: cpu_read(4'hE, 1, got);
        default: repeat (2) cyc();
      endcase
    end
    rnd      = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    cyc();
    cpu_read(4'hE, 1, got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
